// File: rtl/ulx3s_reset_sequencer.sv
// Reset/lock manager behind the ULX3S PLL: filters lock, stretches reset,
// releases per-domain resets in staggered order and retries the PLL on timeout.
module ulx3s_reset_sequencer #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned STRETCH_CYCLES = 64,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned PLL_RST_CYCLES = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_pll_locked,
  input  logic                i_force_reset,
  output logic [CHANNELS-1:0] o_rst_out,
  output logic                o_ready,
  output logic                o_pll_rst,
  output logic [7:0]          o_lock_lost_count,
  output logic                o_timeout
);
  localparam int unsigned MAX_AB = (LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES;
  localparam int unsigned MAX_CD = (STAGGER_CYCLES > PLL_RST_CYCLES) ? STAGGER_CYCLES : PLL_RST_CYCLES;
  localparam int unsigned MAX_4  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_P  = (MAX_4 > TIMEOUT_CYCLES) ? MAX_4 : TIMEOUT_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_P + 1);
  localparam int unsigned RW     = $clog2(CHANNELS + 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_FILTER,
    S_STRETCH,
    S_RELEASE,
    S_RUN,
    S_PLLRST
  } state_t;

  logic                r_sync;
  logic                r_locked_s;
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_timer;
  logic [RW-1:0]       r_rel;
  logic [CHANNELS-1:0] r_rst_out;
  logic                r_ready;
  logic                r_pll_rst;
  logic [7:0]          r_lost;
  logic                r_timeout;

  state_t              w_state_nx;
  logic [CW-1:0]       w_cnt_nx;
  logic [CW-1:0]       w_timer_nx;
  logic [CW-1:0]       w_timer_inc;
  logic [RW-1:0]       w_rel_nx;
  logic [CHANNELS-1:0] w_rst_out_nx;
  logic                w_ready_nx;
  logic                w_pll_rst_nx;
  logic [7:0]          w_lost_nx;
  logic                w_timeout_nx;

  assign w_timer_inc = r_timer + CW'(1);

  // Next-state and next-output logic; outputs are derived from the next state
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_timer_nx   = r_timer;
    w_rel_nx     = r_rel;
    w_lost_nx    = r_lost;
    w_timeout_nx = r_timeout;
    w_rst_out_nx = '1;
    w_ready_nx   = 1'b0;
    w_pll_rst_nx = 1'b0;

    unique case (r_state)
      S_WAIT_LOCK, S_FILTER: begin
        w_timer_nx = w_timer_inc;
        if (w_timer_inc == CW'(TIMEOUT_CYCLES)) begin
          w_state_nx   = S_PLLRST;
          w_cnt_nx     = '0;
          w_timeout_nx = 1'b1;
        end else if (i_force_reset && r_locked_s) begin
          w_state_nx = S_STRETCH;
          w_cnt_nx   = '0;
          w_timer_nx = '0;
        end else if (!r_locked_s) begin
          w_state_nx = S_WAIT_LOCK;
        end else if (r_state == S_WAIT_LOCK) begin
          w_state_nx = S_FILTER;
          w_cnt_nx   = '0;
        end else if (r_cnt == CW'(LOCK_FILTER - 1)) begin
          w_state_nx = S_STRETCH;
          w_cnt_nx   = '0;
          w_timer_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_STRETCH, S_RELEASE, S_RUN: begin
        // Lock loss outranks a simultaneous force request
        if (!r_locked_s) begin
          w_state_nx = S_WAIT_LOCK;
          w_timer_nx = '0;
          if (r_lost != 8'hFF) w_lost_nx = r_lost + 8'd1;
        end else if (i_force_reset) begin
          w_state_nx = S_STRETCH;
          w_cnt_nx   = '0;
        end else if (r_state == S_STRETCH) begin
          if (r_cnt == CW'(STRETCH_CYCLES - 1)) begin
            w_state_nx = S_RELEASE;
            w_cnt_nx   = '0;
            w_rel_nx   = RW'(1);
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end else if (r_state == S_RELEASE) begin
          if (r_rel == RW'(CHANNELS)) begin
            w_state_nx = S_RUN;
          end else if (r_cnt == CW'(STAGGER_CYCLES - 1)) begin
            w_rel_nx = r_rel + RW'(1);
            w_cnt_nx = '0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
      end
      S_PLLRST: begin
        if (r_cnt == CW'(PLL_RST_CYCLES - 1)) begin
          w_state_nx = S_WAIT_LOCK;
          w_cnt_nx   = '0;
          w_timer_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = S_WAIT_LOCK;
    endcase

    w_ready_nx   = (w_state_nx == S_RUN);
    w_pll_rst_nx = (w_state_nx == S_PLLRST);
    if (w_state_nx == S_RUN) begin
      w_rst_out_nx = '0;
    end else if (w_state_nx == S_RELEASE) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (RW'(k) < w_rel_nx) w_rst_out_nx[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync     <= 1'b0;
      r_locked_s <= 1'b0;
      r_state    <= S_WAIT_LOCK;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_rel      <= '0;
      r_rst_out  <= '1;
      r_ready    <= 1'b0;
      r_pll_rst  <= 1'b0;
      r_lost     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_sync     <= i_pll_locked;
      r_locked_s <= r_sync;
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_timer    <= w_timer_nx;
      r_rel      <= w_rel_nx;
      r_rst_out  <= w_rst_out_nx;
      r_ready    <= w_ready_nx;
      r_pll_rst  <= w_pll_rst_nx;
      r_lost     <= w_lost_nx;
      r_timeout  <= w_timeout_nx;
    end
  end

  assign o_rst_out         = r_rst_out;
  assign o_ready           = r_ready;
  assign o_pll_rst         = r_pll_rst;
  assign o_lock_lost_count = r_lost;
  assign o_timeout         = r_timeout;

endmodule

// File: tb/tb_ulx3s_reset_sequencer.sv
// Bench for ulx3s_reset_sequencer: timeline-based reference model plus
// directed and randomized lock/force stimulus.
module tb_ulx3s_reset_sequencer;
  localparam int CH = 3;
  localparam int LF = 4;
  localparam int SC = 8;
  localparam int SG = 2;
  localparam int TO = 50;
  localparam int PR = 5;
  localparam logic [13:0] RESET_VEC = {3'b111, 1'b0, 1'b0, 1'b0, 8'd0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll = 1'b0;
  logic          frc = 1'b0;
  logic [CH-1:0] rst_out;
  logic          ready;
  logic          pll_rst;
  logic [7:0]    lost_cnt;
  logic          tmo;
  logic [13:0]   dut_vec;
  logic [13:0]   exp_vec;
  int            checks = 0;
  int            errors = 0;

  ulx3s_reset_sequencer #(
    .CHANNELS(CH), .LOCK_FILTER(LF), .STRETCH_CYCLES(SC),
    .STAGGER_CYCLES(SG), .TIMEOUT_CYCLES(TO), .PLL_RST_CYCLES(PR)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_pll_locked(pll), .i_force_reset(frc),
    .o_rst_out(rst_out), .o_ready(ready), .o_pll_rst(pll_rst),
    .o_lock_lost_count(lost_cnt), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  assign dut_vec = {rst_out, ready, pll_rst, tmo, lost_cnt};

  // Reference model: tracks event timestamps (edge numbers) and derives outputs arithmetically
  int m_n, m_timer_t0, m_pll_t0, m_seq_t0, m_run, m_cnt;
  bit m_p1, m_p2, m_in_pll, m_in_seq, m_filt, m_to;

  always @(posedge clk or posedge rst) begin : model
    bit         ls;
    int         d;
    logic [2:0] er;
    logic       erd;
    if (rst) begin
      m_n = 0; m_timer_t0 = 0; m_pll_t0 = 0; m_seq_t0 = 0; m_run = 0; m_cnt = 0;
      m_p1 = 0; m_p2 = 0; m_in_pll = 0; m_in_seq = 0; m_filt = 0; m_to = 0;
    end else begin
      m_n++;
      ls = m_p2; m_p2 = m_p1; m_p1 = pll;
      if (m_in_pll) begin
        if (m_n - m_pll_t0 == PR) begin m_in_pll = 0; m_timer_t0 = m_n; m_filt = 0; end
      end else if (m_in_seq) begin
        if (!ls) begin
          m_in_seq = 0; m_filt = 0; m_timer_t0 = m_n;
          if (m_cnt < 255) m_cnt++;
        end else if (frc) m_seq_t0 = m_n;
      end else if (m_n - m_timer_t0 == TO) begin
        m_in_pll = 1; m_pll_t0 = m_n; m_to = 1; m_filt = 0;
      end else if (ls && (frc || (m_filt && m_run + 1 == LF))) begin
        m_in_seq = 1; m_seq_t0 = m_n; m_filt = 0;
      end else if (!ls) m_filt = 0;
      else if (!m_filt) begin m_filt = 1; m_run = 0; end
      else m_run++;
    end
    er = 3'b111; erd = 1'b0;
    if (m_in_seq) begin
      d = m_n - m_seq_t0;
      for (int k = 0; k < CH; k++) if (d >= SC + k * SG) er[k] = 1'b0;
      erd = (d >= SC + (CH - 1) * SG + 1);
    end
    exp_vec = {er, erd, m_in_pll, m_to, 8'(m_cnt)};
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; pll = 1'b0; frc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bring_up();
    pll = 1'b1;
    repeat (22) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL reset_state: got %b expected %b", dut_vec, RESET_VEC);
    end
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++; $display("FAIL reset_model: got %b expected %b", dut_vec, exp_vec);
    end
  endtask

  task automatic test_nominal();
    logic [2:0] pr;
    apply_reset();
    pll = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL nominal_model edge %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
      pr = 3'b111;
      for (int k = 0; k < CH; k++) if (i >= 14 + 2 * k) pr[k] = 1'b0;
      checks++;
      if ({rst_out, ready, lost_cnt} !== {pr, (i >= 19), 8'd0}) begin
        errors++; $display("FAIL nominal_plan edge %0d: got %b/%b/%0d expected %b/%b/0",
                           i, rst_out, ready, lost_cnt, pr, (i >= 19));
      end
    end
  endtask

  task automatic test_filter_glitch();
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      pll = (i != 3);
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL glitch_model edge %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
      checks++;
      if ({rst_out, lost_cnt} !== {((i >= 18) ? 3'b110 : 3'b111), 8'd0} && i < 20) begin
        errors++; $display("FAIL glitch_plan edge %0d: got %b/%0d", i, rst_out, lost_cnt);
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [7:0] ec;
    int         low_len;
    apply_reset();
    bring_up();
    for (int it = 0; it < 300; it++) begin
      ec = (it + 1 > 255) ? 8'd255 : 8'(it + 1);
      low_len = int'($urandom_range(1, 4));
      repeat ($urandom_range(0, 3)) tick();
      for (int i = 0; i < low_len + 22; i++) begin
        pll = (i >= low_len);
        tick();
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++; $display("FAIL loss_model it %0d edge %0d: got %b expected %b", it, i, dut_vec, exp_vec);
        end
        if (i < 2 || i == 2 || i == low_len + 19) begin
          checks++;
          if ((i < 2 && {rst_out, ready} !== 4'b0001) ||
              (i == 2 && {rst_out, ready, lost_cnt} !== {3'b111, 1'b0, ec}) ||
              (i == low_len + 19 && {rst_out, ready} !== 4'b0001)) begin
            errors++; $display("FAIL loss_plan it %0d edge %0d: got %b/%b/%0d count expected %0d",
                               it, i, rst_out, ready, lost_cnt, ec);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic ep;
    apply_reset();
    for (int e = 1; e <= 112; e++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL timeout_model edge %0d: got %b expected %b", e, dut_vec, exp_vec);
      end
      ep = (e >= 50 && e < 55) || (e >= 105 && e < 110);
      checks++;
      if ({pll_rst, tmo, rst_out} !== {ep, (e >= 50), 3'b111}) begin
        errors++; $display("FAIL timeout_plan edge %0d: got pll_rst=%b timeout=%b expected %b %b",
                           e, pll_rst, tmo, ep, (e >= 50));
      end
    end
    pll = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL timeout_relock edge %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    checks++;
    if ({rst_out, ready, tmo} !== 5'b00011) begin
      errors++; $display("FAIL timeout_release: got %b/%b/%b expected 000/1/1", rst_out, ready, tmo);
    end
  endtask

  task automatic test_force();
    logic [2:0] pr;
    apply_reset();
    bring_up();
    frc = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      frc = 1'b0;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL force_model edge %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
      pr = 3'b111;
      for (int k = 0; k < CH; k++) if (i >= 8 + 2 * k) pr[k] = 1'b0;
      checks++;
      if ({rst_out, ready, lost_cnt} !== {pr, (i >= 13), 8'd0}) begin
        errors++; $display("FAIL force_plan edge %0d: got %b/%b/%0d expected %b/%b/0",
                           i, rst_out, ready, lost_cnt, pr, (i >= 13));
      end
    end
    pll = 1'b0;
    for (int i = 0; i < 7; i++) begin
      frc = (i == 2);
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL force_loss_model edge %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
      if (i >= 2) begin
        checks++;
        if ({rst_out, ready, lost_cnt} !== {3'b111, 1'b0, 8'd1}) begin
          errors++; $display("FAIL force_loss_plan edge %0d: got %b/%b/%0d expected 111/0/1",
                             i, rst_out, ready, lost_cnt);
        end
      end
    end
    frc = 1'b0;
  endtask

  task automatic test_random();
    int seg;
    apply_reset();
    seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        pll = ~pll;
        seg = pll ? int'($urandom_range(3, 80)) : int'($urandom_range(1, 70));
      end
      seg--;
      frc = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL random_model cycle %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    frc = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    pll = 1'b1;
    repeat (16) tick();
    checks++;
    if (rst_out !== 3'b110) begin
      errors++; $display("FAIL async_pre_release: got %b expected 110", rst_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL async_release: got %b expected %b", dut_vec, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0; pll = 1'b0;
    repeat (52) tick();
    checks++;
    if ({pll_rst, tmo} !== 2'b11) begin
      errors++; $display("FAIL async_pre_pllrst: got %b%b expected 11", pll_rst, tmo);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL async_pllrst: got %b expected %b", dut_vec, RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_filter_glitch();
    test_lock_loss();
    test_timeout();
    test_force();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
